m_pcpi_arbiter: RTL and testbench

- Shares one M-extension unit (PCPI co-processor: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) between two PCPI requesters, e.g. two cores or a core plus a DMA checker.
- Decodes M instructions on each port and grants the unit round-robin.
- Drives the unit's PCPI slave port with registered operands, then routes the result back to the granted requester.
- Sits between the core-side PCPI buses and the M unit.

---
 rtl/m_pcpi_arbiter_pkg.sv | 33 +++
 rtl/m_pcpi_arbiter_if.sv | 49 ++++
 rtl/m_pcpi_arbiter_rr.sv | 31 +++
 rtl/m_pcpi_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_m_pcpi_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_pcpi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_arb_pkg
//  Description : Shared definitions for the PCPI M-extension arbiter: the
//                arbiter state encoding, the M-instruction opcode/func7
//                values, the requester count and the M-instruction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package m_arb_pkg;

    // Number of PCPI requesters sharing the M unit
    localparam int NUM_REQ = 2;

    // RV32M instructions: OP opcode with func7 = 0000001
    localparam logic [6:0] M_OPCODE = 7'b0110011;
    localparam logic [6:0] M_FUNC7  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // True for any of MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. func3 is not
    // inspected: every func3 value under this opcode/func7 is an M op.
    function automatic logic is_m_insn(input logic [31:0] insn);
        logic unused_fields;
        unused_fields = ^insn[24:7];
        return (insn[6:0] == M_OPCODE) && (insn[31:25] == M_FUNC7);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m_pcpi_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : m_pcpi_arbiter_if
//  Description : Bundles the requester-side PCPI buses (one lane per port,
//                packed [port][bit]) and the unit-side PCPI bus.
//                  req_valid/req_insn/req_rs1/req_rs2 : requester -> arbiter
//                  req_wr/req_rd/req_wait/req_ready   : arbiter -> requester
//                  m_valid/m_insn/m_rs1/m_rs2         : arbiter -> M unit
//                  m_wr/m_rd/m_busy/m_ready           : M unit -> arbiter
//                Modport master is the arbiter view, slave the environment
//                view (requesters plus the M unit).
//  Revision    : 1.0 - initial release
// ============================================================================
interface m_pcpi_arbiter_if;

    logic [m_arb_pkg::NUM_REQ-1:0]        req_valid;
    logic [m_arb_pkg::NUM_REQ-1:0][31:0]  req_insn;
    logic [m_arb_pkg::NUM_REQ-1:0][31:0]  req_rs1;
    logic [m_arb_pkg::NUM_REQ-1:0][31:0]  req_rs2;
    logic [m_arb_pkg::NUM_REQ-1:0]        req_wr;
    logic [m_arb_pkg::NUM_REQ-1:0][31:0]  req_rd;
    logic [m_arb_pkg::NUM_REQ-1:0]        req_wait;
    logic [m_arb_pkg::NUM_REQ-1:0]        req_ready;

    logic                                 m_valid;
    logic [31:0]                          m_insn;
    logic [31:0]                          m_rs1;
    logic [31:0]                          m_rs2;
    logic                                 m_wr;
    logic [31:0]                          m_rd;
    logic                                 m_busy;
    logic                                 m_ready;

    modport master (
        input  req_valid, req_insn, req_rs1, req_rs2,
        output req_wr, req_rd, req_wait, req_ready,
        output m_valid, m_insn, m_rs1, m_rs2,
        input  m_wr, m_rd, m_busy, m_ready
    );

    modport slave (
        output req_valid, req_insn, req_rs1, req_rs2,
        input  req_wr, req_rd, req_wait, req_ready,
        input  m_valid, m_insn, m_rs1, m_rs2,
        output m_wr, m_rd, m_busy, m_ready
    );

endinterface
`default_nettype wire

// File: rtl/m_pcpi_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : m_rr_arbiter
//  Description : Combinational two-way round-robin grant. A lone request is
//                granted outright; when both ports request, the port named
//                by i_rr_ptr wins.
//  Ports       : i_req    [1:0]  per-port request
//                i_rr_ptr        preferred port on contention
//                o_grant  [1:0]  one-hot grant (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module m_rr_arbiter
    import m_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_rr_ptr ? 2'b10 : 2'b01;
            default: o_grant = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/m_pcpi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : m_pcpi_arbiter
//  Description : Shares one PCPI M-extension unit between two PCPI
//                requesters. M instructions are decoded per port, the unit is
//                granted round-robin, operands are registered on grant and
//                held on the unit bus, and the result is returned to the
//                granted requester one cycle after the unit's ready.
//  Ports       : clk          rising-edge clock
//                resetn       asynchronous active-low reset
//                bus          m_pcpi_arbiter_if.master (requester + unit bus)
//                arb_timeout  one-cycle abort pulse (0 unless timeout built)
//  Parameters  : TIMEOUT_CYCLES - ISSUE cycles allowed before abort
//                                 (timeout build only)
//  Options     : `define M_ARB_TIMEOUT_EN to build the ISSUE timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_pcpi_arbiter
    import m_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                resetn,
    m_pcpi_arbiter_if.master    bus,
    output logic                arb_timeout
);

    state_t                     r_state;
    state_t                     w_next_state;

    logic                       r_rr_ptr;
    logic                       r_grant;    // index of the port in service
    logic                       r_abort;    // granted requester dropped valid
    logic                       r_wr;
    logic [31:0]                r_rd;
    logic [31:0]                r_insn;
    logic [31:0]                r_rs1;
    logic [31:0]                r_rs2;

    logic [NUM_REQ-1:0]         w_req;
    logic [NUM_REQ-1:0]         w_grant_oh;
    logic                       w_grant_idx;
    logic                       w_any_req;
    logic                       w_timeout;

    logic                       w_m_valid;
    logic [NUM_REQ-1:0]         w_req_ready;
    logic [NUM_REQ-1:0]         w_req_wr;
    logic [NUM_REQ-1:0][31:0]   w_req_rd;

    // ------------------------------------------------------------------
    // Per-port request decode
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_decode
            assign w_req[gi] = bus.req_valid[gi] && is_m_insn(bus.req_insn[gi]);
        end
    endgenerate

    assign w_any_req = |w_req;

    m_rr_arbiter u_rr_arbiter (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant_oh)
    );

    // With two ports the one-hot grant collapses to its upper bit
    assign w_grant_idx = w_grant_oh[1];

    // ------------------------------------------------------------------
    // Optional ISSUE timeout
    // ------------------------------------------------------------------
`ifdef M_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0]         r_tmo_cnt;
    logic                       w_unused;

    // Held at zero outside ISSUE, so it starts from zero on every entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ISSUE) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // A ready arriving on the last allowed cycle still wins over the abort
    assign w_timeout = (r_state == ISSUE) && !bus.m_ready && (r_tmo_cnt == c_tmo_last);
    assign w_unused  = bus.m_busy;
`else
    logic                       w_unused;

    assign w_timeout = 1'b0;
    assign w_unused  = bus.m_busy ^ (TIMEOUT_CYCLES != 0);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = ISSUE;
            ISSUE:   if (bus.m_ready || w_timeout) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_m_valid   = 1'b0;
        w_req_ready = '0;
        w_req_wr    = '0;
        w_req_rd    = '0;
        case (r_state)
            ISSUE: begin
                w_m_valid = !w_timeout;
            end
            RESP: begin
                // m_valid stays low here so the unit cannot restart on stale operands
                if (!r_abort) begin
                    w_req_ready[r_grant] = 1'b1;
                    w_req_wr[r_grant]    = r_wr;
                    w_req_rd[r_grant]    = r_rd;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, operand and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr <= 1'b0;
            r_grant  <= 1'b0;
            r_abort  <= 1'b0;
            r_wr     <= 1'b0;
            r_rd     <= '0;
            r_insn   <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant_idx;
                        r_abort <= 1'b0;
                        r_insn  <= bus.req_insn[w_grant_idx];
                        r_rs1   <= bus.req_rs1[w_grant_idx];
                        r_rs2   <= bus.req_rs2[w_grant_idx];
                    end
                end
                ISSUE: begin
                    // The unit cannot be cancelled: keep issuing, but remember
                    // that nobody is waiting for this result
                    if (!bus.req_valid[r_grant]) begin
                        r_abort <= 1'b1;
                    end
                    if (bus.m_ready) begin
                        r_rd <= bus.m_rd;
                        r_wr <= bus.m_wr;
                    end else if (w_timeout) begin
                        r_rd <= '0;
                        r_wr <= 1'b0;
                    end
                end
                RESP: begin
                    r_rr_ptr <= ~r_grant;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus drive
    // ------------------------------------------------------------------
    assign bus.m_valid   = w_m_valid;
    assign bus.m_insn    = r_insn;
    assign bus.m_rs1     = r_rs1;
    assign bus.m_rs2     = r_rs2;
    assign bus.req_ready = w_req_ready;
    assign bus.req_wr    = w_req_wr;
    assign bus.req_rd    = w_req_rd;
    // Claim the instruction from the first cycle it is seen so the core
    // never flags it as illegal
    assign bus.req_wait  = w_req & ~w_req_ready;
    assign arb_timeout   = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_m_pcpi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_pcpi_arbiter
//  Description : Directed self-checking bench for m_pcpi_arbiter with a
//                behavioural PCPI M unit of programmable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_pcpi_arbiter;
    import m_arb_pkg::*;

    localparam int TB_TIMEOUT = 8;

    logic        clk;
    logic        resetn;
    logic        arb_timeout;

    int          n_pass;
    int          n_total;

    // behavioural unit state
    int          u_cnt;
    int          u_lat;
    logic        u_busy;
    logic        u_hang;
    logic [31:0] u_res;

    m_pcpi_arbiter_if bus ();

    m_pcpi_arbiter #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .arb_timeout (arb_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] unit_calc(input logic [31:0] insn, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (insn[14:12])
            3'b100:  r = $signed(a) / $signed(b);
            3'b101:  r = a / b;
            3'b110:  r = $signed(a) % $signed(b);
            3'b111:  r = a % b;
            default: r = a * b;
        endcase
        return r;
    endfunction

    // PCPI unit model, evaluated mid-cycle
    always @(negedge clk) begin
        if (!resetn) begin
            u_busy      = 1'b0;
            bus.m_ready = 1'b0;
            bus.m_wr    = 1'b0;
            bus.m_rd    = '0;
        end else if (bus.m_ready) begin
            bus.m_ready = 1'b0;
            bus.m_wr    = 1'b0;
            bus.m_rd    = '0;
        end else if (u_busy) begin
            u_cnt = u_cnt - 1;
            if (u_cnt <= 0) begin
                bus.m_ready = 1'b1;
                bus.m_wr    = 1'b1;
                bus.m_rd    = u_res;
                u_busy      = 1'b0;
            end
        end else if (bus.m_valid && !u_hang) begin
            u_busy = 1'b1;
            u_cnt  = u_lat;
            u_res  = unit_calc(bus.m_insn, bus.m_rs1, bus.m_rs2);
        end
        bus.m_busy = u_busy;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_insn  = '0;
        bus.req_rs1   = '0;
        bus.req_rs2   = '0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_inputs();
        u_hang = 1'b0;
        u_lat  = 2;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        n_total++; if (bus.req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); else n_pass++;
        n_total++; if (bus.req_wr !== 2'b00) $display("FAIL reset_req_wr: got %b want 00", bus.req_wr); else n_pass++;
        n_total++; if (bus.req_rd !== 64'd0) $display("FAIL reset_req_rd: got %h want 0", bus.req_rd); else n_pass++;
        n_total++; if (bus.req_wait !== 2'b00) $display("FAIL reset_req_wait: got %b want 00", bus.req_wait); else n_pass++;
        n_total++; if (arb_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", arb_timeout); else n_pass++;
        n_total++; if ({bus.m_insn, bus.m_rs1, bus.m_rs2} !== 96'd0) $display("FAIL reset_operands: got %h want 0", {bus.m_insn, bus.m_rs1, bus.m_rs2}); else n_pass++;
        resetn = 1'b1;
        tick();
        n_total++; if (bus.m_valid !== 1'b0) $display("FAIL reset_idle_m_valid: got %b want 0", bus.m_valid); else n_pass++;
    endtask

    task automatic test_single();
        logic [31:0] mul;
        mul = mk_insn(7'b0000001, 3'b000);
        apply_reset();
        bus.req_insn[0] = mul;
        bus.req_rs1[0]  = 32'd7;
        bus.req_rs2[0]  = 32'd6;
        bus.req_valid[0] = 1'b1;
        #1;
        n_total++; if (bus.req_wait[0] !== 1'b1) $display("FAIL single_wait_same_cycle: got %b want 1", bus.req_wait[0]); else n_pass++;
        n_total++; if (bus.m_valid !== 1'b0) $display("FAIL single_m_valid_early: got %b want 0", bus.m_valid); else n_pass++;
        tick();
        n_total++; if (bus.m_valid !== 1'b1) $display("FAIL single_m_valid_n1: got %b want 1", bus.m_valid); else n_pass++;
        n_total++; if (bus.m_insn !== mul) $display("FAIL single_m_insn: got %h want %h", bus.m_insn, mul); else n_pass++;
        n_total++; if (bus.m_rs2 !== 32'd6) $display("FAIL single_m_rs2: got %0d want 6", bus.m_rs2); else n_pass++;
        bus.req_rs1[0] = 32'd99;
        tick();
        n_total++; if (bus.m_rs1 !== 32'd7) $display("FAIL single_m_rs1_stable: got %0d want 7", bus.m_rs1); else n_pass++;
        for (int k = 0; k < 20 && bus.req_ready[0] !== 1'b1; k++) tick();
        n_total++; if (bus.req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", bus.req_ready); else n_pass++;
        n_total++; if (bus.req_rd[0] !== 32'd42) $display("FAIL single_rd: got %0d want 42", bus.req_rd[0]); else n_pass++;
        n_total++; if (bus.req_wr !== 2'b01) $display("FAIL single_wr: got %b want 01", bus.req_wr); else n_pass++;
        n_total++; if (bus.m_valid !== 1'b0) $display("FAIL single_m_valid_resp: got %b want 0", bus.m_valid); else n_pass++;
        n_total++; if (bus.req_wait[0] !== 1'b0) $display("FAIL single_wait_resp: got %b want 0", bus.req_wait[0]); else n_pass++;
        bus.req_valid[0] = 1'b0;
        tick();
        n_total++; if (bus.req_ready !== 2'b00) $display("FAIL single_ready_pulse: got %b want 00", bus.req_ready); else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic w_ok;
        apply_reset();
        bus.req_insn[0] = mk_insn(7'b0000001, 3'b101);
        bus.req_rs1[0]  = 32'd100;
        bus.req_rs2[0]  = 32'd7;
        bus.req_insn[1] = mk_insn(7'b0000001, 3'b101);
        bus.req_rs1[1]  = 32'd9;
        bus.req_rs2[1]  = 32'd3;
        bus.req_valid   = 2'b11;
        #1;
        n_total++; if (bus.req_wait !== 2'b11) $display("FAIL simul_wait_both: got %b want 11", bus.req_wait); else n_pass++;
        tick();
        n_total++; if (bus.m_rs1 !== 32'd100) $display("FAIL simul_first_port0: got %0d want 100", bus.m_rs1); else n_pass++;
        w_ok = 1'b1;
        for (int k = 0; k < 20 && bus.req_ready[0] !== 1'b1; k++) begin
            if (bus.req_wait[1] !== 1'b1) w_ok = 1'b0;
            tick();
        end
        if (bus.req_wait[1] !== 1'b1) w_ok = 1'b0;
        n_total++; if (w_ok !== 1'b1) $display("FAIL simul_wait1_held: got %b want 1", w_ok); else n_pass++;
        n_total++; if (bus.req_ready !== 2'b01) $display("FAIL simul_ready0: got %b want 01", bus.req_ready); else n_pass++;
        n_total++; if (bus.req_rd[0] !== 32'd14) $display("FAIL simul_rd0: got %0d want 14", bus.req_rd[0]); else n_pass++;
        n_total++; if (bus.req_rd[1] !== 32'd0) $display("FAIL simul_rd1_idle: got %0d want 0", bus.req_rd[1]); else n_pass++;
        bus.req_valid[0] = 1'b0;
        for (int k = 0; k < 20 && bus.req_ready[1] !== 1'b1; k++) tick();
        n_total++; if (bus.req_ready !== 2'b10) $display("FAIL simul_ready1: got %b want 10", bus.req_ready); else n_pass++;
        n_total++; if (bus.req_rd[1] !== 32'd3) $display("FAIL simul_rd1: got %0d want 3", bus.req_rd[1]); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_fairness();
        int p;
        logic [1:0] want;
        apply_reset();
        bus.req_insn[0] = mk_insn(7'b0000001, 3'b000);
        bus.req_rs1[0]  = 32'd7;
        bus.req_rs2[0]  = 32'd6;
        bus.req_insn[1] = mk_insn(7'b0000001, 3'b101);
        bus.req_rs1[1]  = 32'd9;
        bus.req_rs2[1]  = 32'd3;
        bus.req_valid   = 2'b11;
        for (int op = 0; op < 4; op++) begin
            want = (op % 2 == 1) ? 2'b10 : 2'b01;
            for (int k = 0; k < 20 && bus.req_ready === 2'b00; k++) tick();
            n_total++; if (bus.req_ready !== want) $display("FAIL fair_grant_%0d: got %b want %b", op, bus.req_ready, want); else n_pass++;
            p = (bus.req_ready[1] === 1'b1) ? 1 : 0;
            bus.req_valid[p] = 1'b0;
            tick();
            bus.req_valid[p] = 1'b1;
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_non_m();
        logic seen;
        apply_reset();
        bus.req_insn[1] = mk_insn(7'b0000000, 3'b000);
        bus.req_rs1[1]  = 32'd1;
        bus.req_rs2[1]  = 32'd2;
        bus.req_valid[1] = 1'b1;
        #1;
        n_total++; if (bus.req_wait[1] !== 1'b0) $display("FAIL nonm_wait: got %b want 0", bus.req_wait[1]); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.m_valid !== 1'b0) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL nonm_m_valid: got %b want 0", seen); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        int cycles;
        apply_reset();
        u_lat = 8;
        bus.req_insn[0] = mk_insn(7'b0000001, 3'b100);
        bus.req_rs1[0]  = 32'd1000;
        bus.req_rs2[0]  = 32'd10;
        bus.req_insn[1] = mk_insn(7'b0000001, 3'b000);
        bus.req_rs1[1]  = 32'd3;
        bus.req_rs2[1]  = 32'd5;
        bus.req_valid   = 2'b11;
        tick();
        n_total++; if (bus.m_rs1 !== 32'd1000) $display("FAIL abort_first_port0: got %0d want 1000", bus.m_rs1); else n_pass++;
        tick();
        tick();
        tick();
        bus.req_valid[0] = 1'b0;
        cycles = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.m_valid !== 1'b1) break;
            cycles++;
        end
        n_total++; if (cycles !== 5) $display("FAIL abort_m_valid_held: got %0d cycles want 5", cycles); else n_pass++;
        n_total++; if (bus.req_ready !== 2'b00) $display("FAIL abort_no_ready: got %b want 00", bus.req_ready); else n_pass++;
        // port0 comes back immediately; the pointer must favour port1
        u_lat = 2;
        bus.req_insn[0] = mk_insn(7'b0000001, 3'b000);
        bus.req_rs1[0]  = 32'd2;
        bus.req_rs2[0]  = 32'd2;
        bus.req_valid[0] = 1'b1;
        tick();
        tick();
        n_total++; if (bus.m_rs1 !== 32'd3) $display("FAIL abort_next_port1: got %0d want 3", bus.m_rs1); else n_pass++;
        for (int k = 0; k < 20 && bus.req_ready[1] !== 1'b1; k++) tick();
        n_total++; if (bus.req_rd[1] !== 32'd15) $display("FAIL abort_rd1: got %0d want 15", bus.req_rd[1]); else n_pass++;
        bus.req_valid[1] = 1'b0;
        for (int k = 0; k < 20 && bus.req_ready[0] !== 1'b1; k++) tick();
        n_total++; if (bus.req_rd[0] !== 32'd4) $display("FAIL abort_rd0_after: got %0d want 4", bus.req_rd[0]); else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        u_lat = 6;
        bus.req_insn[0] = mk_insn(7'b0000001, 3'b000);
        bus.req_rs1[0]  = 32'd5;
        bus.req_rs2[0]  = 32'd5;
        bus.req_valid[0] = 1'b1;
        tick();
        tick();
        n_total++; if (bus.m_valid !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", bus.m_valid); else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++; if (bus.m_valid !== 1'b0) $display("FAIL rstmid_async: got %b want 0", bus.m_valid); else n_pass++;
        n_total++; if (bus.m_rs1 !== 32'd0) $display("FAIL rstmid_operands: got %0d want 0", bus.m_rs1); else n_pass++;
        bus.req_valid[0] = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        n_total++; if (bus.m_valid !== 1'b0 || bus.req_ready !== 2'b00) $display("FAIL rstmid_idle: got m_valid=%b ready=%b want 0/00", bus.m_valid, bus.req_ready); else n_pass++;
    endtask

`ifdef M_ARB_TIMEOUT_EN
    task automatic test_timeout();
        apply_reset();
        u_hang = 1'b1;
        bus.req_insn[0] = mk_insn(7'b0000001, 3'b000);
        bus.req_rs1[0]  = 32'd7;
        bus.req_rs2[0]  = 32'd6;
        bus.req_valid[0] = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) tick();
        n_total++; if (arb_timeout !== 1'b0 || bus.m_valid !== 1'b1) $display("FAIL tmo_cycle7: got tmo=%b m_valid=%b want 0/1", arb_timeout, bus.m_valid); else n_pass++;
        tick();
        n_total++; if (arb_timeout !== 1'b1) $display("FAIL tmo_pulse: got %b want 1", arb_timeout); else n_pass++;
        n_total++; if (bus.m_valid !== 1'b0) $display("FAIL tmo_m_valid: got %b want 0", bus.m_valid); else n_pass++;
        tick();
        n_total++; if (bus.req_ready !== 2'b01 || bus.req_wr !== 2'b00) $display("FAIL tmo_resp: got ready=%b wr=%b want 01/00", bus.req_ready, bus.req_wr); else n_pass++;
        n_total++; if (arb_timeout !== 1'b0) $display("FAIL tmo_one_cycle: got %b want 0", arb_timeout); else n_pass++;
        bus.req_valid[0] = 1'b0;
        tick();
        n_total++; if (bus.m_valid !== 1'b0 || bus.req_ready !== 2'b00) $display("FAIL tmo_idle: got m_valid=%b ready=%b want 0/00", bus.m_valid, bus.req_ready); else n_pass++;
        u_hang = 1'b0;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        resetn  = 1'b0;
        u_hang  = 1'b0;
        u_lat   = 2;
        clear_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_non_m();
        test_abort();
        test_reset_mid();
`ifdef M_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
